// File: rtl/cdb_pkg.sv
// Shared definitions for the common data bus arbiter.
// Holds bus widths, the invalid ROB tag, the buffered result payload and
// the two-slot round-robin pick helper used by cdb_arbiter.
package cdb_pkg;

  localparam int unsigned ROB_W   = 6;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MAX_REQ = 8;

  localparam logic [ROB_W-1:0] INVALID_ROB = 6'b010000;

  typedef struct packed {
    logic [ROB_W-1:0]  robNum;
    logic [DATA_W-1:0] data;
  } cdb_entry_t;

  typedef struct packed {
    logic [MAX_REQ-1:0] g1;
    logic [MAX_REQ-1:0] g2;
  } grant2_t;

  // Scan from ptr upward modulo n; first set bit wins slot 1, next distinct one slot 2.
  function automatic grant2_t rr_pick2(input logic [MAX_REQ-1:0] valid,
                                       input logic [2:0]         ptr,
                                       input int unsigned        n);
    grant2_t    g;
    logic       found1;
    logic [2:0] idx;
    g      = '0;
    found1 = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = 3'((32'(ptr) + i) % n);
      if ((i < n) && valid[idx] && (g.g2 == '0)) begin
        if (!found1) begin
          g.g1[idx] = 1'b1;
          found1    = 1'b1;
        end else begin
          g.g2[idx] = 1'b1;
        end
      end
    end
    return g;
  endfunction

  // Index of the set bit in a one-hot vector (0 when empty).
  function automatic logic [2:0] oh_index(input logic [MAX_REQ-1:0] oh);
    logic [2:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/cdb_req_fifo.sv
// Per-requester result FIFO (DEPTH entries, DEPTH a power of two >= 2).
// Ports: clock, reset (async, active-high), flush_i (sync clear),
//        push_i/din_i (write, ignored when full), pop_i (read, ignored when empty),
//        head_o (oldest entry), full_o, empty_o.
module cdb_req_fifo
  import cdb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush_i,
  input  logic       push_i,
  input  cdb_entry_t din_i,
  input  logic       pop_i,
  output cdb_entry_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  cdb_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; entries are only read while counted valid.
  always_ff @(posedge clock) begin
    if (do_push && !flush_i) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-slot common data bus arbiter.
// Buffers results from NUM_REQ producers in per-requester FIFOs and every
// cycle grants up to two distinct non-empty FIFOs round-robin onto the
// registered CDB / CDB2 outputs.
// Ports: clock, reset (async, active-high), flush (sync clear),
//        req_valid/req_robNum/req_data (packed per requester), req_ready,
//        CDBiscast/CDBrobNum/CDBdata (slot 1), CDBiscast2/CDBrobNum2/CDBdata2
//        (slot 2), pending (any FIFO non-empty).
// Optional: define CDB_BRANCH_PRIORITY_EN to give requester 0 fixed
//           ownership of slot 1 whenever it has a result.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ROB_W-1:0]  req_robNum,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      CDBiscast,
  output logic [ROB_W-1:0]          CDBrobNum,
  output logic [DATA_W-1:0]         CDBdata,
  output logic                      CDBiscast2,
  output logic [ROB_W-1:0]          CDBrobNum2,
  output logic [DATA_W-1:0]         CDBdata2,
  output logic                      pending
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]              rr_q, rr_d;
  logic [NUM_REQ-1:0]            empty, full, push, pop;
  cdb_entry_t [NUM_REQ-1:0]      head;
  logic [MAX_REQ-1:0]            valid_mask;
  grant2_t                       g;
  cdb_entry_t                    s1, s2;
  logic                          upd1;

  assign req_ready  = ~full;
  assign pending    = |(~empty);
  assign push       = req_valid & ~full;
  assign valid_mask = MAX_REQ'(~empty);

  // Requester FIFOs.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_fifo
    cdb_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .flush_i(flush),
      .push_i (push[k]),
      .din_i  ({req_robNum[k*ROB_W +: ROB_W], req_data[k*DATA_W +: DATA_W]}),
      .pop_i  (pop[k]),
      .head_o (head[k]),
      .full_o (full[k]),
      .empty_o(empty[k])
    );
  end

  // Grant selection from the current FIFO state.
  always_comb begin
    grant2_t gt;
    g  = '0;
    gt = '0;
`ifdef CDB_BRANCH_PRIORITY_EN
    if (valid_mask[0]) begin
      gt   = rr_pick2(valid_mask & ~MAX_REQ'(1), 3'(rr_q), NUM_REQ);
      g.g1 = MAX_REQ'(1);
      g.g2 = gt.g1;
    end else begin
      g = rr_pick2(valid_mask, 3'(rr_q), NUM_REQ);
    end
`else
    gt = rr_pick2(valid_mask, 3'(rr_q), NUM_REQ);
    g  = gt;
`endif
  end

  assign pop = g.g1[NUM_REQ-1:0] | g.g2[NUM_REQ-1:0];

  // A slot-1 grant to the branch requester does not advance the pointer.
`ifdef CDB_BRANCH_PRIORITY_EN
  assign upd1 = (g.g1 != '0) && !g.g1[0];
`else
  assign upd1 = (g.g1 != '0);
`endif

  always_comb begin
    rr_d = rr_q;
    if (g.g2 != '0) begin
      rr_d = PTR_W'((32'(oh_index(g.g2)) + 32'd1) % NUM_REQ);
    end else if (upd1) begin
      rr_d = PTR_W'((32'(oh_index(g.g1)) + 32'd1) % NUM_REQ);
    end
  end

  // Slot payload muxes; an ungranted slot carries the idle pattern.
  always_comb begin
    s1 = '{robNum: INVALID_ROB, data: '0};
    s2 = '{robNum: INVALID_ROB, data: '0};
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (g.g1[k]) s1 = head[k];
      if (g.g2[k]) s2 = head[k];
    end
  end

  // Registered bus outputs and round-robin pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_q       <= '0;
      CDBiscast  <= 1'b0;
      CDBrobNum  <= INVALID_ROB;
      CDBdata    <= '0;
      CDBiscast2 <= 1'b0;
      CDBrobNum2 <= INVALID_ROB;
      CDBdata2   <= '0;
    end else if (flush) begin
      CDBiscast  <= 1'b0;
      CDBrobNum  <= INVALID_ROB;
      CDBdata    <= '0;
      CDBiscast2 <= 1'b0;
      CDBrobNum2 <= INVALID_ROB;
      CDBdata2   <= '0;
    end else begin
      rr_q       <= rr_d;
      CDBiscast  <= |g.g1;
      CDBrobNum  <= s1.robNum;
      CDBdata    <= s1.data;
      CDBiscast2 <= |g.g2;
      CDBrobNum2 <= s2.robNum;
      CDBdata2   <= s2.data;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N = 4;
  localparam int D = 2;
`ifdef CDB_BRANCH_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic                clock = 1'b0;
  logic                reset;
  logic                flush;
  logic [N-1:0]        req_valid;
  logic [N*ROB_W-1:0]  req_robNum;
  logic [N*DATA_W-1:0] req_data;
  logic [N-1:0]        req_ready;
  logic                CDBiscast, CDBiscast2, pending;
  logic [ROB_W-1:0]    CDBrobNum, CDBrobNum2;
  logic [DATA_W-1:0]   CDBdata, CDBdata2;

  cdb_arbiter #(.NUM_REQ(N), .DEPTH(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_robNum(req_robNum),
    .req_data  (req_data),
    .req_ready (req_ready),
    .CDBiscast (CDBiscast),
    .CDBrobNum (CDBrobNum),
    .CDBdata   (CDBdata),
    .CDBiscast2(CDBiscast2),
    .CDBrobNum2(CDBrobNum2),
    .CDBdata2  (CDBdata2),
    .pending   (pending)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: one queue of {rob, data} per requester plus a scan pointer.
  logic [ROB_W+DATA_W-1:0] mq [N][$];
  int                      rr;
  logic                    e_cast1, e_cast2;
  logic [ROB_W-1:0]        e_rob1, e_rob2;
  logic [DATA_W-1:0]       e_d1, e_d2;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) mq[k].delete();
    rr = 0;
  endtask

  task automatic model_step(input logic fl, input logic [N-1:0] v,
                            input logic [N*ROB_W-1:0] r, input logic [N*DATA_W-1:0] d);
    bit rdy [N];
    int s1, s2;
    logic [ROB_W+DATA_W-1:0] e;
    for (int k = 0; k < N; k++) rdy[k] = (mq[k].size() < D);
    e_cast1 = 1'b0; e_rob1 = INVALID_ROB; e_d1 = '0;
    e_cast2 = 1'b0; e_rob2 = INVALID_ROB; e_d2 = '0;
    if (fl) begin
      for (int k = 0; k < N; k++) mq[k].delete();
      return;
    end
    s1 = -1;
    s2 = -1;
    if (PRIO && mq[0].size() > 0) s1 = 0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (rr + i) % N;
      if (mq[k].size() > 0 && k != s1) begin
        if (s1 < 0) s1 = k;
        else if (s2 < 0) s2 = k;
      end
    end
    if (s2 >= 0) rr = (s2 + 1) % N;
    else if (s1 >= 0 && !(PRIO && s1 == 0)) rr = (s1 + 1) % N;
    if (s1 >= 0) begin
      e = mq[s1].pop_front();
      e_cast1 = 1'b1; e_rob1 = e[ROB_W+DATA_W-1:DATA_W]; e_d1 = e[DATA_W-1:0];
    end
    if (s2 >= 0) begin
      e = mq[s2].pop_front();
      e_cast2 = 1'b1; e_rob2 = e[ROB_W+DATA_W-1:DATA_W]; e_d2 = e[DATA_W-1:0];
    end
    for (int k = 0; k < N; k++) begin
      if (v[k] && rdy[k]) mq[k].push_back({r[k*ROB_W +: ROB_W], d[k*DATA_W +: DATA_W]});
    end
  endtask

  // One clock: called and returns at a negedge.
  task automatic cycle(input logic fl, input logic [N-1:0] v,
                       input logic [N*ROB_W-1:0] r, input logic [N*DATA_W-1:0] d);
    logic [N-1:0] e_rdy;
    logic         e_pend;
    e_pend = 1'b0;
    for (int k = 0; k < N; k++) begin
      e_rdy[k] = (mq[k].size() < D);
      if (mq[k].size() > 0) e_pend = 1'b1;
    end
    flush = fl; req_valid = v; req_robNum = r; req_data = d;
    #1;
    check_eq("req_ready", req_ready, e_rdy);
    check_eq("pending", pending, e_pend);
    model_step(fl, v, r, d);
    @(posedge clock);
    #1;
    check_eq("cast1", CDBiscast, e_cast1);
    check_eq("rob1", CDBrobNum, e_rob1);
    check_eq("data1", CDBdata, e_d1);
    check_eq("cast2", CDBiscast2, e_cast2);
    check_eq("rob2", CDBrobNum2, e_rob2);
    check_eq("data2", CDBdata2, e_d2);
    @(negedge clock);
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, '0);
  endtask

  task automatic random_cycle(input int flush_pct);
    logic [N-1:0]        v;
    logic [N*ROB_W-1:0]  r;
    logic [N*DATA_W-1:0] d;
    for (int k = 0; k < N; k++) begin
      v[k] = ($urandom_range(99) < 60);
      r[k*ROB_W +: ROB_W]   = ROB_W'($urandom);
      d[k*DATA_W +: DATA_W] = $urandom;
    end
    cycle(($urandom_range(99) < flush_pct), v, r, d);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cast1"}, CDBiscast, 1'b0);
    check_eq({tag, "_cast2"}, CDBiscast2, 1'b0);
    check_eq({tag, "_rob1"}, CDBrobNum, 6'b010000);
    check_eq({tag, "_rob2"}, CDBrobNum2, 6'b010000);
    check_eq({tag, "_data1"}, CDBdata, 32'd0);
    check_eq({tag, "_data2"}, CDBdata2, 32'd0);
    check_eq({tag, "_ready"}, req_ready, 4'b1111);
    check_eq({tag, "_pending"}, pending, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; req_valid = '0; req_robNum = '0; req_data = '0;
    @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [N*ROB_W-1:0]  r;
    logic [N*DATA_W-1:0] d;
    int                  sent;

    model_clear();
    do_reset();

    // Idle after reset.
    for (int i = 0; i < 5; i++) idle();
    check_reset_outputs("idle");

    // Single result from requester 2.
    r = '0; d = '0;
    r[2*ROB_W +: ROB_W]   = 6'd5;
    d[2*DATA_W +: DATA_W] = 32'h12345678;
    cycle(1'b0, 4'b0100, r, d);
    idle();
    check_eq("single_cast1", CDBiscast, 1'b1);
    check_eq("single_rob1", CDBrobNum, 6'd5);
    check_eq("single_data1", CDBdata, 32'h12345678);
    check_eq("single_cast2", CDBiscast2, 1'b0);
    idle();
    check_eq("single_once", CDBiscast, 1'b0);

    // Four-way contention from a reset pointer, twice to show the pointer returns to 0.
    do_reset();
    for (int round = 0; round < 2; round++) begin
      for (int k = 0; k < N; k++) begin
        r[k*ROB_W +: ROB_W]   = ROB_W'(k + 1);
        d[k*DATA_W +: DATA_W] = 32'(32'hA000 + k);
      end
      cycle(1'b0, 4'b1111, r, d);
      idle();
      check_eq("four_A_rob1", CDBrobNum, 6'd1);
      check_eq("four_A_rob2", CDBrobNum2, 6'd2);
      idle();
      check_eq("four_B_rob1", CDBrobNum, 6'd3);
      check_eq("four_B_rob2", CDBrobNum2, 6'd4);
      check_eq("four_B_cast2", CDBiscast2, 1'b1);
    end

    // Backpressure: requester 1 offers three results while the others stay busy.
    sent = 0;
    for (int i = 0; i < 14; i++) begin
      bit acc;
      for (int k = 0; k < N; k++) begin
        r[k*ROB_W +: ROB_W]   = ROB_W'($urandom);
        d[k*DATA_W +: DATA_W] = $urandom;
      end
      r[1*ROB_W +: ROB_W] = ROB_W'(10 + sent);
      acc = (sent < 3) && (mq[1].size() < D);
      cycle(1'b0, 4'b1101 | ((sent < 3) ? 4'b0010 : 4'b0000), r, d);
      if (acc) sent++;
    end
    check_eq("bp_all_sent", 32'(sent), 32'd3);
    for (int i = 0; i < 8; i++) idle();

    // Flush with three buffered results and one new push.
    r = '0; d = '0;
    for (int k = 0; k < N; k++) begin
      r[k*ROB_W +: ROB_W]   = ROB_W'(20 + k);
      d[k*DATA_W +: DATA_W] = 32'(32'hF000 + k);
    end
    cycle(1'b0, 4'b0111, r, d);
    cycle(1'b1, 4'b1000, r, d);
    check_eq("flush_cast1", CDBiscast, 1'b0);
    check_eq("flush_cast2", CDBiscast2, 1'b0);
    check_eq("flush_pending", pending, 1'b0);
    for (int i = 0; i < 4; i++) idle();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 1500; i++) random_cycle(4);

    // Async reset while slot 1 is broadcasting.
    for (int i = 0; i < 50 && CDBiscast !== 1'b1; i++) random_cycle(0);
    check_eq("burst_reached", CDBiscast, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) idle();

`ifdef CDB_BRANCH_PRIORITY_EN
    // Requesters 0 and 3 push every cycle: 0 owns slot 1, 3 gets slot 2.
    for (int i = 0; i < 12; i++) begin
      r = '0; d = '0;
      r[0*ROB_W +: ROB_W] = 6'h01; d[0*DATA_W +: DATA_W] = 32'(i);
      r[3*ROB_W +: ROB_W] = 6'h33; d[3*DATA_W +: DATA_W] = 32'(100 + i);
      cycle(1'b0, 4'b1001, r, d);
      if (i >= 1) begin
        check_eq("prio_rob1", CDBrobNum, 6'h01);
        check_eq("prio_rob2", CDBrobNum2, 6'h33);
      end
    end
    for (int i = 0; i < 4; i++) idle();
`endif

    for (int i = 0; i < 200; i++) random_cycle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
